// File: rtl/mda_adc_filter_pkg.sv
// Shared constants, FSM state type and output rounding for the ADC EMA filter.
// Optional feature macro used by the filter files: MDA_ADC_FILTER_BYPASS_EN.
package mda_adc_pkg;

    localparam int unsigned ADC_BITS = 12;
    localparam int unsigned CH_WORD  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StUpdate,
        StPublish
    } state_e;

    // Round-half-up from FRAC fractional bits, saturated to the ADC full scale.
    function automatic logic [ADC_BITS-1:0] round_out(input logic [31:0] acc,
                                                      input int unsigned frac);
        logic [32:0] sum;
        logic [32:0] scaled;
        sum    = {1'b0, acc} + (33'd1 << (frac - 1));
        scaled = sum >> frac;
        if (scaled > 33'((1 << ADC_BITS) - 1)) begin
            return {ADC_BITS{1'b1}};
        end
        return scaled[ADC_BITS-1:0];
    endfunction

endpackage

// File: rtl/mda_adc_filter_if.sv
// Raw-sample in / filtered-sample out bundle of the ADC filter.
// With MDA_ADC_FILTER_BYPASS_EN defined the bundle carries a bypass request.
interface mda_adc_filter_if
    import mda_adc_pkg::*;
#(
    parameter int unsigned NUM_CH = 8
);
    logic                        enable;
    logic [NUM_CH*CH_WORD-1:0]   adc_channels;
    logic [NUM_CH*CH_WORD-1:0]   filt_channels;
    logic                        filt_valid;
    logic [31:0]                 sample_count;
`ifdef MDA_ADC_FILTER_BYPASS_EN
    logic                        bypass;
`endif

    modport master (
`ifdef MDA_ADC_FILTER_BYPASS_EN
        output bypass,
`endif
        output enable,
        output adc_channels,
        input  filt_channels,
        input  filt_valid,
        input  sample_count
    );

    modport slave (
`ifdef MDA_ADC_FILTER_BYPASS_EN
        input  bypass,
`endif
        input  enable,
        input  adc_channels,
        output filt_channels,
        output filt_valid,
        output sample_count
    );

endinterface

// File: rtl/mda_adc_filter_ema.sv
// Combinational single-channel EMA step: acc += (x<<FRAC - acc) >>> SHIFT, or prime to x<<FRAC.
module mda_ema_update
    import mda_adc_pkg::*;
#(
    parameter int unsigned SHIFT = 3,
    parameter int unsigned FRAC  = 4
) (
    input  logic [ADC_BITS-1:0]      i_x,
    input  logic [ADC_BITS+FRAC-1:0] i_acc,
    input  logic                     i_primed,
    output logic [ADC_BITS+FRAC-1:0] o_acc_next,
    output logic                     o_out_of_range
);
    localparam int unsigned AccW = ADC_BITS + FRAC;
    localparam logic [AccW-1:0] MaxAcc = {{ADC_BITS{1'b1}}, {FRAC{1'b0}}};

    logic        [AccW-1:0] w_x_sh;
    logic signed [AccW:0]   w_diff;
    logic signed [AccW:0]   w_step;
    logic signed [AccW:0]   w_sum;

    always_comb begin
        w_x_sh = {i_x, {FRAC{1'b0}}};
        w_diff = $signed({1'b0, w_x_sh}) - $signed({1'b0, i_acc});
        w_step = w_diff >>> SHIFT;
        w_sum  = $signed({1'b0, i_acc}) + w_step;
        o_acc_next     = i_primed ? w_sum[AccW-1:0] : w_x_sh;
        // The update is a convex step toward x, so leaving range means a broken datapath.
        o_out_of_range = i_primed && (w_sum[AccW] || (w_sum[AccW-1:0] > MaxAcc));
    end

endmodule

// File: rtl/mda_adc_filter.sv
// Periodic snapshot + time-multiplexed per-channel EMA of the packed ADC bus.
// Define MDA_ADC_FILTER_BYPASS_EN to add a bypass that publishes raw snapshots.
module mda_adc_filter
    import mda_adc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned SHIFT      = 3,
    parameter int unsigned FRAC       = 4
) (
    input logic             spi_clk,
    input logic             reset_n,
    mda_adc_filter_if.slave bus
);
    localparam int unsigned AccW = ADC_BITS + FRAC;
    localparam int unsigned CntW = $clog2(SAMPLE_DIV);
    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (SAMPLE_DIV < NUM_CH + 3) begin : g_bad_div
        $error("SAMPLE_DIV must be at least NUM_CH+3");
    end
    if (FRAC < 1) begin : g_bad_frac
        $error("FRAC must be at least 1");
    end

    state_e                    r_state;
    state_e                    w_state_next;
    logic   [CntW-1:0]         r_tick_cnt;
    logic                      w_tick;
    logic   [IdxW-1:0]         r_ch_idx;
    logic                      w_last_ch;
    logic                      w_do_capture;
    logic                      w_do_update;
    logic                      w_do_publish;
    logic   [ADC_BITS-1:0]     r_snap [NUM_CH];
    logic   [AccW-1:0]         r_acc  [NUM_CH];
    logic                      r_primed;
    logic   [AccW-1:0]         w_acc_next;
    logic                      w_out_of_range;
    logic   [ADC_BITS-1:0]     w_pub  [NUM_CH];
    logic   [NUM_CH*CH_WORD-1:0] r_filt_channels;
    logic                      r_filt_valid;
    logic   [31:0]             r_sample_count;

    assign w_tick    = bus.enable && (r_tick_cnt == CntW'(SAMPLE_DIV - 1));
    assign w_last_ch = (r_ch_idx == IdxW'(NUM_CH - 1));

    always_ff @(posedge spi_clk) begin
        if (!reset_n || !bus.enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge spi_clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_tick) w_state_next = StCapture;
            StCapture: w_state_next = StUpdate;
            StUpdate:  if (w_last_ch) w_state_next = StPublish;
            StPublish: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_do_capture = 1'b0;
        w_do_update  = 1'b0;
        w_do_publish = 1'b0;
        unique case (r_state)
            StCapture: w_do_capture = 1'b1;
            StUpdate:  w_do_update  = 1'b1;
            StPublish: w_do_publish = 1'b1;
            default:   ;
        endcase
    end

    mda_ema_update #(
        .SHIFT (SHIFT),
        .FRAC  (FRAC)
    ) u_ema (
        .i_x            (r_snap[r_ch_idx]),
        .i_acc          (r_acc[r_ch_idx]),
        .i_primed       (r_primed),
        .o_acc_next     (w_acc_next),
        .o_out_of_range (w_out_of_range)
    );

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_pub[k] = round_out(32'(r_acc[k]), FRAC);
`ifdef MDA_ADC_FILTER_BYPASS_EN
            if (bus.bypass) w_pub[k] = r_snap[k];
`endif
        end
    end

    always_ff @(posedge spi_clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_snap[k] <= '0;
                r_acc[k]  <= '0;
            end
            r_ch_idx        <= '0;
            r_primed        <= 1'b0;
            r_filt_channels <= '0;
            r_filt_valid    <= 1'b0;
            r_sample_count  <= '0;
        end else begin
            r_filt_valid <= 1'b0;
            if (w_do_capture) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_snap[k] <= bus.adc_channels[k*CH_WORD +: ADC_BITS];
                end
                r_ch_idx <= '0;
            end
            if (w_do_update) begin
                r_acc[r_ch_idx] <= w_acc_next;
                r_ch_idx        <= r_ch_idx + 1'b1;
            end
            if (w_do_publish) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_filt_channels[k*CH_WORD +: CH_WORD] <=
                        {{(CH_WORD - ADC_BITS){1'b0}}, w_pub[k]};
                end
                r_filt_valid   <= 1'b1;
                r_primed       <= 1'b1;
                r_sample_count <= r_sample_count + 32'd1;
            end
        end
    end

    assign bus.filt_channels = r_filt_channels;
    assign bus.filt_valid    = r_filt_valid;
    assign bus.sample_count  = r_sample_count;

    a_acc_in_range: assert property (@(posedge spi_clk) disable iff (!reset_n)
        (r_state == StUpdate) |-> !w_out_of_range);

endmodule

// File: tb/tb_mda_adc_filter.sv
// Self-checking bench for mda_adc_filter against an arithmetic EMA model.
// Exercises the bypass path too when MDA_ADC_FILTER_BYPASS_EN is defined.
module tb_mda_adc_filter;
    import mda_adc_pkg::*;

    localparam int unsigned NumCh     = 8;
    localparam int unsigned SampleDiv = 16;
    localparam int unsigned Shift     = 3;
    localparam int unsigned Frac      = 4;
    localparam int unsigned BusW      = NumCh * CH_WORD;
    localparam int          PubLat    = NumCh + 3;
    localparam int          HistN     = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int next_exp = 0;

    logic [BusW-1:0] hist     [HistN];
    logic            hist_byp [HistN];
    int              m_acc    [NumCh];
    int              m_out    [NumCh];
    bit              m_primed;
    int              m_count;

    mda_adc_filter_if #(.NUM_CH(NumCh)) bus_if ();

    mda_adc_filter #(
        .NUM_CH     (NumCh),
        .SAMPLE_DIV (SampleDiv),
        .SHIFT      (Shift),
        .FRAC       (Frac)
    ) u_dut (
        .spi_clk (clk),
        .reset_n (rst_n),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic cur_byp();
`ifdef MDA_ADC_FILTER_BYPASS_EN
        return bus_if.bypass;
`else
        return 1'b0;
`endif
    endfunction

    // Record what the DUT sees during this cycle, then advance one clock.
    task automatic step();
        hist[cyc % HistN]     = bus_if.adc_channels;
        hist_byp[cyc % HistN] = cur_byp();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Channel value in the low 12 bits, random junk above to prove it is ignored.
    task automatic set_ch(input int k, input int v);
        logic [31:0] w;
        w       = $urandom;
        w[11:0] = v[11:0];
        bus_if.adc_channels[k*CH_WORD +: CH_WORD] = w;
    endtask

    task automatic rand_bus();
        for (int k = 0; k < NumCh; k++) set_ch(k, int'($urandom_range(0, 4095)));
    endtask

    function automatic int floor_shift(input int d);
        int den;
        den = 1 << Shift;
        if (d >= 0) return d / den;
        return -((-d + den - 1) / den);
    endfunction

    function automatic logic [BusW-1:0] pack_model();
        logic [BusW-1:0] p;
        for (int k = 0; k < NumCh; k++) p[k*CH_WORD +: CH_WORD] = 32'(m_out[k]);
        return p;
    endfunction

    task automatic model_pass(input logic [BusW-1:0] snap, input logic byp);
        int x;
        int filt;
        for (int k = 0; k < NumCh; k++) begin
            x = int'(snap[k*CH_WORD +: ADC_BITS]);
            if (!m_primed) m_acc[k] = x * (1 << Frac);
            else           m_acc[k] = m_acc[k] + floor_shift(x * (1 << Frac) - m_acc[k]);
            filt = (m_acc[k] + (1 << (Frac - 1))) / (1 << Frac);
            if (filt > 4095) filt = 4095;
            m_out[k] = byp ? x : filt;
        end
        m_primed = 1'b1;
        m_count++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NumCh; k++) begin
            m_acc[k] = 0;
            m_out[k] = 0;
        end
        m_primed = 1'b0;
        m_count  = 0;
    endtask

    // Wait (bounded) for the next publish; check timing, hold, values and pulse width.
    task automatic wait_pub(input bit rnd);
        bit hold_ok;
        int n;
        hold_ok = 1'b1;
        n       = 0;
        while (bus_if.filt_valid !== 1'b1 && n < 400) begin
            if (bus_if.filt_channels !== pack_model()) hold_ok = 1'b0;
            if (rnd && $urandom_range(3) == 0) rand_bus();
            step();
            n++;
        end
        check_eq("hold", 32'(hold_ok), 32'd1);
        check_eq("valid_time", cyc, next_exp);
        if (bus_if.filt_valid === 1'b1) begin
            model_pass(hist[(cyc - PubLat + 1) % HistN], hist_byp[(cyc - 1) % HistN]);
            for (int k = 0; k < NumCh; k++) begin
                check_eq($sformatf("ch%0d", k), bus_if.filt_channels[k*CH_WORD +: CH_WORD],
                         32'(m_out[k]));
            end
            check_eq("sample_count", bus_if.sample_count, 32'(m_count));
        end
        next_exp += SampleDiv;
        step();
        check_eq("pulse_width", 32'(bus_if.filt_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        check_eq("rst_valid", 32'(bus_if.filt_valid), 32'd0);
        check_eq("rst_count", bus_if.sample_count, 32'd0);
        check_eq("rst_filt_any", 32'(|bus_if.filt_channels), 32'd0);
        rst_n    = 1'b1;
        cyc      = 0;
        next_exp = SampleDiv - 1 + PubLat;
        model_reset();
    endtask

    initial begin
        int prev;
        int obs;
        bit quiet;
        int keep [NumCh];

        bus_if.enable = 1'b1;
`ifdef MDA_ADC_FILTER_BYPASS_EN
        bus_if.bypass = 1'b0;
`endif
        for (int k = 0; k < NumCh; k++) set_ch(k, 0);
        model_reset();
        step();
        step();

        // Priming with a constant channel 0.
        set_ch(0, 1000);
        for (int k = 1; k < NumCh; k++) set_ch(k, int'($urandom_range(0, 4095)));
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wait_pub(1'b0);
            check_eq("prime_ch0", bus_if.filt_channels[31:0], 32'd1000);
            check_eq("prime_count", bus_if.sample_count, 32'(i));
        end

        // Enable gating.
        bus_if.enable = 1'b0;
        quiet = 1'b1;
        repeat (100) begin
            step();
            if (bus_if.filt_valid !== 1'b0) quiet = 1'b0;
        end
        check_eq("disabled_quiet", 32'(quiet), 32'd1);
        bus_if.enable = 1'b1;
        next_exp = cyc + SampleDiv - 1 + PubLat;
        wait_pub(1'b0);

        // Randomized inputs changing at random cycles.
        repeat (6) wait_pub(1'b1);

        // Reset while channel 4 is being updated, then re-prime.
        for (int k = 0; k < NumCh; k++) begin
            keep[k] = int'($urandom_range(0, 4095));
            set_ch(k, keep[k]);
        end
        while (cyc < next_exp - 5) step();
        do_reset();
        wait_pub(1'b0);
        for (int k = 0; k < NumCh; k++) begin
            check_eq($sformatf("reprime_ch%0d", k),
                     bus_if.filt_channels[k*CH_WORD +: CH_WORD], 32'(keep[k]));
        end

        // Snapshot isolation on channel 3.
        set_ch(3, 100);
        do_reset();
        wait_pub(1'b0);
        wait_pub(1'b0);
        while (cyc < next_exp - 7) step();
        set_ch(3, 3000);
        wait_pub(1'b0);
        check_eq("iso_same_pass", bus_if.filt_channels[3*CH_WORD +: CH_WORD], 32'd100);
        wait_pub(1'b0);
        check_eq("iso_next_pass", bus_if.filt_channels[3*CH_WORD +: CH_WORD], 32'd463);

        // Up-step 0 -> 4095.
        set_ch(0, 0);
        do_reset();
        wait_pub(1'b0);
        set_ch(0, 4095);
        wait_pub(1'b0);
        check_eq("up_first", bus_if.filt_channels[31:0], 32'd512);
        prev = 512;
        repeat (80) begin
            wait_pub(1'b0);
            obs = int'(bus_if.filt_channels[31:0]);
            check_eq("up_mono", 32'(obs >= prev && obs <= 4095), 32'd1);
            prev = obs;
        end
        check_eq("up_final", bus_if.filt_channels[31:0], 32'd4095);

        // Down-step 4095 -> 0.
        set_ch(0, 4095);
        do_reset();
        wait_pub(1'b0);
        set_ch(0, 0);
        wait_pub(1'b0);
        check_eq("down_first", bus_if.filt_channels[31:0], 32'd3583);
        prev = 3583;
        repeat (85) begin
            wait_pub(1'b0);
            obs = int'(bus_if.filt_channels[31:0]);
            check_eq("down_mono", 32'(obs <= prev), 32'd1);
            prev = obs;
        end
        check_eq("down_final", bus_if.filt_channels[31:0], 32'd0);

`ifdef MDA_ADC_FILTER_BYPASS_EN
        // Bypass during an up-step, then resume filtering without re-prime.
        set_ch(0, 0);
        do_reset();
        wait_pub(1'b0);
        bus_if.bypass = 1'b1;
        set_ch(0, 4095);
        wait_pub(1'b0);
        check_eq("byp_raw", bus_if.filt_channels[31:0], 32'd4095);
        bus_if.bypass = 1'b0;
        wait_pub(1'b0);
        check_eq("byp_resume", bus_if.filt_channels[31:0], 32'd960);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mda_adc_filter.md
Name: mda_adc_filter

Overview:
- Downstream consumer of the 8-channel ADC block's packed `adc_channels` bus.
- Periodically snapshots all channels and runs a per-channel exponential moving average (EMA), time-multiplexed through one update datapath.
- Republishes filtered values in the same packed 32-bit-per-channel format, with a one-cycle valid strobe, for the depth-sensor / register-map logic.
- Runs on the ADC's `spi_clk` domain, so no CDC is needed.

Parameters:
- NUM_CH, 8: number of channels.
- SAMPLE_DIV, 1000: `spi_clk` cycles between sample ticks. Elaboration error if less than NUM_CH+3.
- SHIFT, 3: EMA coefficient is alpha = 1/2^SHIFT.
- FRAC, 4: fractional bits kept in each accumulator. Must be at least 1.

Ports:
- spi_clk  in  1  sole clock.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  gates the sample tick counter.
- adc_channels  in  NUM_CH*32  packed raw samples; channel k occupies [k*32+11:k*32]; upper 20 bits ignored.
- filt_channels  out  NUM_CH*32  packed filtered samples, {20'd0, 12-bit value} per channel.
- filt_valid  out  1  one-cycle pulse when filt_channels has just been updated.
- sample_count  out  32  number of published passes since reset; wraps at 2^32.

Behaviour:
- Reset (reset_n low at a rising edge) clears all of the following:
  - filt_channels=0, filt_valid=0, sample_count=0.
  - Tick counter=0, all accumulators=0, primed=0, state=IDLE.
  - Reset during any state aborts the pass immediately; no partial publish occurs.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while enable=1, then wraps.
  - tick=1 in the cycle where the count equals SAMPLE_DIV-1.
  - enable=0 holds the counter at 0 and suppresses tick. An in-progress pass still completes.
- FSM states and transitions:
  - IDLE: on tick go to CAPTURE.
  - CAPTURE (1 cycle): register the 12-bit field of every channel into a snapshot array; ch_idx=0; go to UPDATE.
  - UPDATE (NUM_CH cycles): process channel ch_idx from the snapshot, increment ch_idx, and go to PUBLISH after channel NUM_CH-1.
  - PUBLISH (1 cycle): register outputs, set primed=1, increment sample_count, return to IDLE.
  - A tick cannot occur outside IDLE, guaranteed by the SAMPLE_DIV constraint.
- Accumulator update, per channel:
  - x = snapshot value, 12 bits, unsigned. acc is 12+FRAC bits, unsigned.
  - If primed=0: acc <= x<<FRAC.
  - Else: d = signed(x<<FRAC) - signed(acc), width 13+FRAC; acc <= acc + (d >>> SHIFT), arithmetic shift.
  - The result never leaves [0, 4095<<FRAC]; no clamp is needed, but this is asserted in simulation.
- Output value: (acc + 2^(FRAC-1)) >> FRAC, saturated to 4095, zero-extended to 32 bits.
- Latency:
  - tick in cycle T; filt_channels update and filt_valid=1 are both visible in cycle T+NUM_CH+3.
  - filt_valid is exactly 1 cycle wide and low otherwise.
  - filt_channels holds its value between publishes.
- Changes on adc_channels after CAPTURE do not affect the current pass.

Optional Feature:
- Macro: MDA_ADC_FILTER_BYPASS_EN.
- Defined: extra input port `bypass` (1 bit), sampled in PUBLISH.
  - bypass=1: filt_channels takes the raw snapshot values instead of the filtered values.
  - Accumulators still update every pass, so deasserting bypass resumes filtered output with no re-prime.
- Undefined: the `bypass` port is absent and the output is always filtered.

Decomposition:
- Package mda_adc_pkg holds:
  - ADC_BITS=12 and CH_WORD=32.
  - The FSM state enum {IDLE, CAPTURE, UPDATE, PUBLISH}.
  - The output-rounding function.
- Sub-module mda_ema_update: a combinational single-channel datapath.
  - Inputs: x, acc, primed.
  - Output: acc_next.
  - Parameterised by SHIFT and FRAC; instantiated once and shared across channels.

Test Plan (NUM_CH=8, SAMPLE_DIV=16, SHIFT=3, FRAC=4):
- Priming: reset released at cycle 0, enable=1, ch0=1000 held constant → first filt_valid at cycle 26, then every 16 cycles. filt_channels[31:0]=32'd1000, and sample_count increments 1, 2, 3 on successive pulses.
- Up-step: primed with ch0=0, then ch0=4095 → next publish shows 512 (acc 8190), and subsequent values rise monotonically to 4095, never exceeding it.
- Down-step: primed with ch0=4095, then ch0=0 → next publish shows 3583 (acc 57330), decaying monotonically to 0.
- Snapshot isolation: change ch3 from 100 to 3000 during UPDATE of a primed pass → that pass publishes 100 for ch3; the next pass publishes 463.
- Reset mid-UPDATE: reset_n low for 1 cycle during the UPDATE state (when ch_idx=4) → all outputs 0, no filt_valid that pass; the next pass re-primes (constant input appears unfiltered).
- Enable and bypass:
  - enable=0 for 100 cycles → no filt_valid and counter held at 0; re-enable → pulse 26 cycles later.
  - With MDA_ADC_FILTER_BYPASS_EN defined and bypass=1 during the up-step → output 4095 immediately.
